// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between NUM_REQ requesters.
// Each operation goes IDLE -> EXEC -> RESP, and the response is held until it is consumed.
module alu_share_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [4*NUM_REQ-1:0]    req_op,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic [31:0]             alu_a,
  output logic [31:0]             alu_b,
  output logic [3:0]              alu_op,
  input  logic [31:0]             alu_result,
  input  logic                    alu_zero,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_result,
  output logic                    rsp_zero,
  output logic                    rsp_err,
  output logic [1:0]              dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid[i] & req_ready[i];
  // a response transfers on a rising edge where rsp_valid & rsp_ready.
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t          r_state;
  logic [ID_W-1:0] r_rr_ptr;
  logic [3:0]      r_op;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  logic [ID_W-1:0] r_id;
  logic            r_rsp_valid;
  logic [ID_W-1:0] r_rsp_id;
  logic [31:0]     r_rsp_result;
  logic            r_rsp_zero;
  logic            r_rsp_err;

  logic            w_hi_found;
  logic [ID_W-1:0] w_hi_idx;
  logic            w_lo_found;
  logic [ID_W-1:0] w_lo_idx;
  logic            w_win_found;
  logic [ID_W-1:0] w_win_idx;
  logic [NUM_REQ-1:0] w_grant;
  logic [3:0]      w_sel_op;
  logic [31:0]     w_sel_a;
  logic [31:0]     w_sel_b;
  logic [ID_W-1:0] w_rr_next;
  logic            w_accept;

  // The search wraps: the lowest valid index at or above rr_ptr wins;
  // if there is none, the lowest valid index below rr_ptr wins.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_found = 1'b0;
    w_lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (i >= int'(r_rr_ptr)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = ID_W'(i);
        end else begin
          w_lo_found = 1'b1;
          w_lo_idx   = ID_W'(i);
        end
      end
    end
    w_win_found = w_hi_found | w_lo_found;
    w_win_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
    w_grant     = '0;
    w_sel_op    = '0;
    w_sel_a     = '0;
    w_sel_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win_found && (w_win_idx == ID_W'(i))) begin
        w_grant[i] = 1'b1;
        w_sel_op   = req_op[4*i +: 4];
        w_sel_a    = req_a[32*i +: 32];
        w_sel_b    = req_b[32*i +: 32];
      end
    end
  end

  assign w_rr_next = (w_win_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;
  assign req_ready = (rst_n && (r_state == IDLE)) ? w_grant : '0;
  assign w_accept  = rst_n && (r_state == IDLE) && w_win_found;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op     <= w_sel_op;
            r_a      <= w_sel_a;
            r_b      <= w_sel_b;
            r_id     <= w_win_idx;
            r_rr_ptr <= w_rr_next;
            // Opcodes 10..15 skip the ALU and answer with an error response.
            if (w_sel_op > 4'd9) begin
              r_rsp_valid  <= 1'b1;
              r_rsp_id     <= w_win_idx;
              r_rsp_result <= '0;
              r_rsp_zero   <= 1'b0;
              r_rsp_err    <= 1'b1;
              r_state      <= RESP;
            end else begin
              r_state <= EXEC;
            end
          end
        end
        EXEC: begin
          r_rsp_valid  <= 1'b1;
          r_rsp_id     <= r_id;
          r_rsp_result <= alu_result;
          r_rsp_zero   <= alu_zero;
          r_rsp_err    <= 1'b0;
          r_state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // ALU inputs come straight from the capture registers, so they stay quiet while the block is idle.
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_op     = r_op;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_err    = r_rsp_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter, with a behavioural ALU and a response scoreboard.
module tb_alu_share_arbiter;
  localparam int N = 2;
  localparam int W = 35;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [4*N-1:0]  req_op;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [31:0]   alu_a;
  logic [31:0]   alu_b;
  logic [3:0]    alu_op;
  logic [31:0]   alu_result;
  logic          alu_zero;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [0:0]    rsp_id;
  logic [31:0]   rsp_result;
  logic          rsp_zero;
  logic          rsp_err;
  logic [1:0]    dbg_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .dbg_state(dbg_state)
  );

  always_comb begin
    case (alu_op)
      4'd0:    alu_result = alu_a + alu_b;
      4'd1:    alu_result = alu_a - alu_b;
      4'd2:    alu_result = alu_a & alu_b;
      4'd3:    alu_result = alu_a | alu_b;
      4'd4:    alu_result = alu_a ^ alu_b;
      4'd5:    alu_result = alu_a << alu_b[4:0];
      4'd6:    alu_result = alu_a >> alu_b[4:0];
      4'd7:    alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      4'd8:    alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'd9:    alu_result = {31'd0, alu_a < alu_b};
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected got %h exp none", {rsp_id, rsp_err, rsp_zero, rsp_result});
      end else begin
        mon_e = exp_q.pop_front();
        if ({rsp_id, rsp_err, rsp_zero, rsp_result} !== mon_e) begin
          errors++;
          $display("FAIL rsp got %h exp %h", {rsp_id, rsp_err, rsp_zero, rsp_result}, mon_e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic do_op(input int id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic z, input logic e, input int lat);
    int got_k;
    int n;
    got_k = -1;
    req_op[4*id +: 4]  = op;
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    req_valid[id]      = 1'b1;
    for (int k = 0; k < 20 && got_k < 0; k++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        got_k = k;
        exp_q.push_back({1'(id), e, z, res});
      end
      @(posedge clk); #1;
    end
    req_valid[id] = 1'b0;
    if (got_k < 0) begin
      checks++; errors++;
      $display("FAIL grant_timeout got none exp req%0d", id);
    end else begin
      check("grant_wait", 32'(got_k), 32'd0);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!rsp_valid && n < 10);
      check("latency", 32'(n), 32'(lat));
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int wait_n;
    int got;
    rst_n = 1'b0; req_valid = '1; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;

    // reset holds everything at zero even with all requests valid
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_rsp_flags", {30'd0, rsp_zero, rsp_err}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    @(posedge clk); #1;
    req_valid = '0; rst_n = 1'b1; rsp_ready = 1'b1;

    // single operations
    do_op(0, 4'd0, 32'd5, 32'd10, 32'd15, 1'b0, 1'b0, 2);
    do_op(0, 4'd1, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 2);
    do_op(1, 4'd4, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 1'b0, 1'b0, 2);
    do_op(0, 4'd6, 32'h80000000, 32'd31, 32'd1, 1'b0, 1'b0, 2);

    // round robin with both requesters continuously valid
    do_reset();
    req_op = {4'd7, 4'd5};
    req_a  = {32'hF0000000, 32'h00000001};
    req_b  = {32'd4, 32'd31};
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      wait_n = 0; got = 0;
      while (!got && wait_n < 10) begin
        @(negedge clk);
        wait_n++;
        if (req_ready != '0) begin
          got = 1;
          check("rr_grant", 32'(req_ready), 32'(2'b01 << (g % 2)));
          if (g > 0) check("rr_gap", 32'(wait_n), 32'd3);
          if (g % 2 == 0) exp_q.push_back({1'b0, 1'b0, 1'b0, 32'h80000000});
          else            exp_q.push_back({1'b1, 1'b0, 1'b0, 32'hFF000000});
        end
        @(posedge clk); #1;
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL rr_timeout got none exp grant %0d", g);
      end
    end
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;

    // backpressure: response held, no grants, input changes ignored
    rsp_ready = 1'b0;
    do_op(0, 4'd8, 32'hFFFFFFFB, 32'd10, 32'd1, 1'b0, 1'b0, 2);
    req_a[31:0] = 32'h12345678;
    req_op[7:4] = 4'd0;
    req_valid = 2'b11;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_result", rsp_result, 32'd1);
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_alu_a", alu_a, 32'hFFFFFFFB);
      @(posedge clk); #1;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_idle", 32'(dbg_state), 32'd0);
    check("bp_released", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;

    // illegal opcode, then a legal one
    do_op(1, 4'hC, 32'd7, 32'd9, 32'd0, 1'b0, 1'b1, 1);
    do_op(1, 4'd9, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 2);

    // reset while an op is in EXEC
    req_op[3:0] = 4'd0; req_a[31:0] = 32'd3; req_b[31:0] = 32'd4;
    req_valid = 2'b01;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (req_ready[0]) got = 1;
      @(posedge clk); #1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL midrst_timeout got none exp grant");
    end
    check("midrst_exec", 32'(dbg_state), 32'd1);
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    req_op = {4'd3, 4'd0};
    req_a  = {32'h0000F000, 32'd2};
    req_b  = {32'h0000000F, 32'd2};
    req_valid = 2'b11;
    @(negedge clk);
    check("midrst_tie", 32'(req_ready), 32'd1);
    if (req_ready[0]) exp_q.push_back({1'b0, 1'b0, 1'b0, 32'd4});
    @(posedge clk); #1;
    req_valid = '0;
    repeat (5) @(posedge clk);
    #1;

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
